// File: rtl/stream_demux_reg.sv
// ----------------------------------------------------------------------------
// stream_demux_reg
//   Registered 1-to-NUM_CH stream demultiplexer with a valid/ready handshake.
//   Each output channel owns a one-entry holding register, so a stalled
//   consumer only blocks words addressed to its own channel. A word can be
//   sent to one channel (in_sel) or to every channel (in_bcast). A select
//   that names no channel is accepted and dropped, and this sets a sticky
//   error flag.
//
//   Optional build macro: STREAM_DEMUX_DROP_CNT_EN adds an 8-bit saturating
//   count (drop_cnt) of dropped out-of-range words.
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block can accept the input word this cycle (combinational)
//   in_data    input word
//   in_sel     destination channel index
//   in_bcast   write the word to every channel; in_sel is ignored
//   out_valid  per-channel valid, bit i is channel i
//   out_ready  per-channel consumer ready
//   out_data   channel i occupies bits [i*DATA_W +: DATA_W]
//   err_sel    sticky flag: an out-of-range select was consumed
//   err_clr    synchronous clear of err_sel (and drop_cnt)
//   drop_cnt   (STREAM_DEMUX_DROP_CNT_EN only) count of dropped words
// ----------------------------------------------------------------------------
module stream_demux_reg #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned SEL_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_bcast,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     err_sel,
   input  logic                     err_clr
`ifdef STREAM_DEMUX_DROP_CNT_EN
   ,
   output logic [7:0]               drop_cnt
`endif
);

   logic [NUM_CH-1:0]              valid_q;
   logic [NUM_CH-1:0][DATA_W-1:0]  data_q;
   logic                           err_q;

   logic [NUM_CH-1:0] free;
   logic [NUM_CH-1:0] load;
   logic              sel_in_range;
   logic              sel_free;
   logic              accept;
   logic              sink;

   assign sel_in_range = (32'(in_sel) < NUM_CH);

   always_comb begin
      // A slot being drained this cycle can take a new word on the same edge.
      free     = ~valid_q | out_ready;
      sel_free = 1'b0;
      load     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (in_sel == SEL_W'(i)) begin
            sel_free = free[i];
         end
      end

      if (in_bcast) begin
         in_ready = &free;
      end else if (sel_in_range) begin
         in_ready = sel_free;
      end else begin
         // Out-of-range words are always sunk.
         in_ready = 1'b1;
      end

      accept = in_valid & in_ready;
      for (int i = 0; i < NUM_CH; i++) begin
         load[i] = accept & (in_bcast | (sel_in_range & (in_sel == SEL_W'(i))));
      end
      sink = accept & ~in_bcast & ~sel_in_range;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (load[i]) begin
               valid_q[i] <= 1'b1;
               data_q[i]  <= in_data;
            end else if (out_ready[i]) begin
               // Data is left in place; only valid drops.
               valid_q[i] <= 1'b0;
            end
         end

         if (sink) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign err_sel   = err_q;

`ifdef STREAM_DEMUX_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= 8'd0;
      end else if (sink && err_clr) begin
         // Clear then count: the drop in this cycle survives the clear.
         drop_cnt_q <= 8'd1;
      end else if (sink) begin
         if (drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end else if (err_clr) begin
         drop_cnt_q <= 8'd0;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_reg.sv
// ----------------------------------------------------------------------------
// tb_stream_demux_reg
//   Self-checking bench for stream_demux_reg. Instance dut uses the default
//   8 channels; instance dut6 uses NUM_CH=6 so that selects 6 and 7 are out of
//   range. Accepted words are pushed to a scoreboard queue and popped when the
//   registered outputs are sampled one edge later.
// ----------------------------------------------------------------------------
module tb_stream_demux_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [2:0]  in_sel;
   logic        in_bcast;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic [63:0] out_data;
   logic        err_sel;
   logic        err_clr;

   logic        b_in_valid;
   logic        b_in_ready;
   logic [5:0]  b_out_valid;
   logic [5:0]  b_out_ready;
   logic [47:0] b_out_data;
   logic        b_err_sel;
`ifdef STREAM_DEMUX_DROP_CNT_EN
   logic [7:0]  drop_cnt;
   logic [7:0]  b_drop_cnt;
`endif

   stream_demux_reg #(.DATA_W(8), .NUM_CH(8), .SEL_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_bcast  (in_bcast),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err_sel   (err_sel),
      .err_clr   (err_clr)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   stream_demux_reg #(.DATA_W(8), .NUM_CH(6), .SEL_W(3)) dut6 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_bcast  (in_bcast),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .err_sel   (b_err_sel),
      .err_clr   (err_clr)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      ,
      .drop_cnt  (b_drop_cnt)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int         ch;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   function automatic logic [7:0] ch_data(input int i);
      return out_data[i*8 +: 8];
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] sel, input logic bc, input logic [7:0] d);
      in_valid = 1'b1;
      in_sel   = sel;
      in_bcast = bc;
      in_data  = d;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0;
      out_ready = '0; err_clr = 1'b0; b_in_valid = 1'b0; b_out_ready = '0;
      #12;
      n_cmp++;
      if (out_valid !== 8'h00 || out_data !== 64'h0 || err_sel !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got v=%h d=%h e=%b want v=00 d=0 e=0",
                  out_valid, out_data, err_sel);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_unicast();
      exp_t e;
      out_ready = 8'hFF;
      drive(3'd3, 1'b0, 8'hA5);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL unicast_ready: got %b want 1", in_ready);
      end
      sb.push_back('{3, 8'hA5});
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 8'h08) begin
         n_err++;
         $display("FAIL unicast_valid: got %h want 08", out_valid);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (ch_data(e.ch) !== e.data) begin
            n_err++;
            $display("FAIL unicast_data ch%0d: got %h want %h", e.ch, ch_data(e.ch), e.data);
         end
      end
      step();
      n_cmp++;
      if (out_valid !== 8'h00 || ch_data(3) !== 8'hA5) begin
         n_err++;
         $display("FAIL unicast_drain: got v=%h d3=%h want v=00 d3=a5", out_valid, ch_data(3));
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [7:0]  words [4];
      words = '{8'h01, 8'h82, 8'h43, 8'hC4};
      out_ready = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         drive(3'd1, 1'b0, words[k]);
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready);
         end
         sb.push_back('{1, words[k]});
         step();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 8'h02 || ch_data(e.ch) !== e.data) begin
               n_err++;
               $display("FAIL b2b_word[%0d]: got v=%h d=%h want v=02 d=%h",
                        k, out_valid, ch_data(e.ch), e.data);
            end
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      exp_t e;
      out_ready = 8'hDF;
      drive(3'd5, 1'b0, 8'h11);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_first_ready: got %b want 1", in_ready);
      end
      sb.push_back('{5, 8'h11});
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_valid[5] !== 1'b1 || ch_data(5) !== e.data) begin
            n_err++;
            $display("FAIL bp_first_word: got v=%b d=%h want v=1 d=%h",
                     out_valid[5], ch_data(5), e.data);
         end
      end
      drive(3'd5, 1'b0, 8'h22);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_stall_ready: got %b want 0", in_ready);
      end
      step();
      n_cmp++;
      if (out_valid[5] !== 1'b1 || ch_data(5) !== 8'h11) begin
         n_err++;
         $display("FAIL bp_hold: got v=%b d=%h want v=1 d=11", out_valid[5], ch_data(5));
      end
      out_ready = 8'hFF;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release_ready: got %b want 1", in_ready);
      end
      sb.push_back('{5, 8'h22});
      step();
      in_valid = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_valid[5] !== 1'b1 || ch_data(5) !== e.data) begin
            n_err++;
            $display("FAIL bp_second_word: got v=%b d=%h want v=1 d=%h",
                     out_valid[5], ch_data(5), e.data);
         end
      end
      step();
   endtask

   task automatic test_independence();
      exp_t e;
      out_ready = 8'hFB;
      drive(3'd2, 1'b0, 8'h44);
      step();
      drive(3'd6, 1'b0, 8'h33);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL indep_ready: got %b want 1", in_ready);
      end
      sb.push_back('{6, 8'h33});
      step();
      in_valid = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_valid !== 8'h44 || ch_data(e.ch) !== e.data || ch_data(2) !== 8'h44) begin
            n_err++;
            $display("FAIL indep_word: got v=%h d6=%h d2=%h want v=44 d6=%h d2=44",
                     out_valid, ch_data(6), ch_data(2), e.data);
         end
      end
      step();
      n_cmp++;
      if (out_valid !== 8'h04) begin
         n_err++;
         $display("FAIL indep_stalled_only: got %h want 04", out_valid);
      end
   endtask

   task automatic test_broadcast();
      exp_t e;
      // Channel 2 is still full; it drains in the accept cycle, so it counts as free.
      out_ready = 8'hFF;
      drive(3'd0, 1'b1, 8'h5A);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bcast_ready: got %b want 1", in_ready);
      end
      for (int i = 0; i < 8; i++) sb.push_back('{i, 8'h5A});
      step();
      n_cmp++;
      if (out_valid !== 8'hFF) begin
         n_err++;
         $display("FAIL bcast_valid: got %h want ff", out_valid);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (ch_data(e.ch) !== e.data) begin
            n_err++;
            $display("FAIL bcast_data ch%0d: got %h want %h", e.ch, ch_data(e.ch), e.data);
         end
      end
      out_ready = 8'hFE;
      drive(3'd4, 1'b1, 8'hC3);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bcast_block_ready: got %b want 0", in_ready);
      end
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 8'h01 || out_data !== {8{8'h5A}}) begin
         n_err++;
         $display("FAIL bcast_blocked: got v=%h d=%h want v=01 d=5a..5a", out_valid, out_data);
      end
      out_ready = 8'hFF;
      step();
   endtask

   task automatic test_out_of_range();
      in_valid    = 1'b0;
      b_out_ready = 6'h3F;
      b_in_valid  = 1'b1;
      in_bcast    = 1'b0;
      in_sel      = 3'd7;
      in_data     = 8'h77;
      #1;
      n_cmp++;
      if (b_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL oor_ready: got %b want 1", b_in_ready);
      end
      step();
      n_cmp++;
      if (b_out_valid !== 6'h00 || b_err_sel !== 1'b1) begin
         n_err++;
         $display("FAIL oor_sink: got v=%h e=%b want v=00 e=1", b_out_valid, b_err_sel);
      end
`ifdef STREAM_DEMUX_DROP_CNT_EN
      n_cmp++;
      if (b_drop_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL oor_cnt1: got %0d want 1", b_drop_cnt);
      end
`endif
      in_sel = 3'd6;
      step();
`ifdef STREAM_DEMUX_DROP_CNT_EN
      n_cmp++;
      if (b_drop_cnt !== 8'd2) begin
         n_err++;
         $display("FAIL oor_cnt2: got %0d want 2", b_drop_cnt);
      end
`endif
      // Set wins over clear in the same cycle.
      err_clr = 1'b1;
      step();
      n_cmp++;
      if (b_err_sel !== 1'b1) begin
         n_err++;
         $display("FAIL oor_set_wins: got %b want 1", b_err_sel);
      end
`ifdef STREAM_DEMUX_DROP_CNT_EN
      n_cmp++;
      if (b_drop_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL oor_cnt_inc_wins: got %0d want 1", b_drop_cnt);
      end
`endif
      b_in_valid = 1'b0;
      step();
      err_clr = 1'b0;
      n_cmp++;
      if (b_err_sel !== 1'b0 || err_sel !== 1'b0) begin
         n_err++;
         $display("FAIL oor_clear: got b=%b main=%b want 0 0", b_err_sel, err_sel);
      end
      // Highest in-range channel of the 6-channel instance still works.
      b_in_valid = 1'b1;
      in_sel     = 3'd5;
      in_data    = 8'h9C;
      step();
      b_in_valid = 1'b0;
      n_cmp++;
      if (b_out_valid !== 6'h20 || b_out_data[47:40] !== 8'h9C || b_err_sel !== 1'b0) begin
         n_err++;
         $display("FAIL oor_inrange: got v=%h d5=%h e=%b want v=20 d5=9c e=0",
                  b_out_valid, b_out_data[47:40], b_err_sel);
      end
      step();
   endtask

   task automatic test_async_reset();
      exp_t e;
      b_in_valid = 1'b1;
      in_sel     = 3'd7;
      step();
      b_in_valid = 1'b0;
      out_ready  = 8'h00;
      drive(3'd2, 1'b0, 8'hAB);
      step();
      drive(3'd5, 1'b0, 8'hCD);
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 8'h24 || b_err_sel !== 1'b1) begin
         n_err++;
         $display("FAIL arst_setup: got v=%h e=%b want v=24 e=1", out_valid, b_err_sel);
      end
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 8'h00 || out_data !== 64'h0 || b_err_sel !== 1'b0) begin
         n_err++;
         $display("FAIL arst_immediate: got v=%h d=%h e=%b want v=00 d=0 e=0",
                  out_valid, out_data, b_err_sel);
      end
      #2;
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 8'h00) begin
         n_err++;
         $display("FAIL arst_no_replay: got %h want 00", out_valid);
      end
      out_ready = 8'hFF;
      drive(3'd0, 1'b0, 8'h5E);
      sb.push_back('{0, 8'h5E});
      step();
      in_valid = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_valid !== 8'h01 || ch_data(e.ch) !== e.data) begin
            n_err++;
            $display("FAIL arst_first_accept: got v=%h d0=%h want v=01 d0=%h",
                     out_valid, ch_data(0), e.data);
         end
      end
      step();
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_back_to_back();
      test_backpressure();
      test_independence();
      test_broadcast();
      test_out_of_range();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
